apu_pulse_sequencer: RTL and testbench

Initiator for the pulse channel's period/duty ready/valid inputs. It holds an 8-entry note table of {duty, period} entries written by a host. On start, it pushes each note onto the period and duty channels in turn, then holds the note for a programmable number of clock cycles before moving to the next. It sits between the host/register interface and apu_pulse, driving apu__period_r*/apu__duty_r* directly.

---
 rtl/apu_pulse_sequencer.sv | 166 ++++++++++++++++
 tb/tb_apu_pulse_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_pulse_sequencer.sv
// Note-table sequencer for the pulse channel: plays up to DEPTH {duty, period}
// notes by handshaking each note onto the period/duty ready/valid channels,
// then holding it for a programmable number of cycles.
module apu_pulse_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TEMPO_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [12:0]        wr_data,
  input  logic [ADDR_W:0]    len,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic [10:0]        period_s,
  output logic               period_s_vld,
  input  logic               period_s_rdy,
  output logic [1:0]         duty_s,
  output logic               duty_s_vld,
  input  logic               duty_s_rdy,
  output logic               busy,
  output logic [ADDR_W-1:0]  note_idx,
  output logic               done
);

  localparam logic [ADDR_W:0]    DEPTH_L   = DEPTH[ADDR_W:0];
  localparam logic [TEMPO_W-1:0] TEMPO_ONE = {{(TEMPO_W-1){1'b0}}, 1'b1};

  // S_LOAD is the entry cycle of SEND: the table is read and vld is raised
  // on the following edge.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_HOLD} state_t;

  state_t             state, state_n;
  logic [12:0]        table_q [DEPTH];
  logic [ADDR_W:0]    len_q, len_n;
  logic [TEMPO_W-1:0] tempo_q, tempo_n;
  logic [TEMPO_W-1:0] cnt_q, cnt_n;
  logic               loop_q, loop_n;
  logic               abort_q, abort_n;
  logic [ADDR_W-1:0]  idx_n;
  logic [10:0]        period_n;
  logic [1:0]         duty_n;
  logic               p_vld_n, d_vld_n, done_n;
  logic               p_fin, d_fin, last_note;

  assign busy      = (state != S_IDLE);
  assign p_fin     = !period_s_vld || period_s_rdy;
  assign d_fin     = !duty_s_vld || duty_s_rdy;
  assign last_note = ({1'b0, note_idx} == (len_q - 1'b1));

  // Note table storage, host writable at any time
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      len_q        <= '0;
      tempo_q      <= '0;
      loop_q       <= 1'b0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      note_idx     <= '0;
      period_s     <= '0;
      duty_s       <= '0;
      period_s_vld <= 1'b0;
      duty_s_vld   <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      len_q        <= len_n;
      tempo_q      <= tempo_n;
      loop_q       <= loop_n;
      cnt_q        <= cnt_n;
      abort_q      <= abort_n;
      note_idx     <= idx_n;
      period_s     <= period_n;
      duty_s       <= duty_n;
      period_s_vld <= p_vld_n;
      duty_s_vld   <= d_vld_n;
      done         <= done_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n  = state;
    len_n    = len_q;
    tempo_n  = tempo_q;
    loop_n   = loop_q;
    cnt_n    = cnt_q;
    abort_n  = abort_q;
    idx_n    = note_idx;
    period_n = period_s;
    duty_n   = duty_s;
    p_vld_n  = period_s_vld;
    d_vld_n  = duty_s_vld;
    done_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        abort_n = 1'b0;
        if (start && !stop && (len != '0)) begin
          len_n   = (len > DEPTH_L) ? DEPTH_L : len;
          tempo_n = (tempo == '0) ? TEMPO_ONE : tempo;
          loop_n  = loop;
          idx_n   = '0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        // Nothing is on the wires yet, so a stop here can leave at once.
        if (stop) begin
          state_n = S_IDLE;
        end else begin
          period_n = table_q[note_idx][10:0];
          duty_n   = table_q[note_idx][12:11];
          p_vld_n  = 1'b1;
          d_vld_n  = 1'b1;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        if (period_s_vld && period_s_rdy) p_vld_n = 1'b0;
        if (duty_s_vld && duty_s_rdy)     d_vld_n = 1'b0;
        if (p_fin && d_fin) begin
          cnt_n   = tempo_q;
          state_n = (abort_q || stop) ? S_IDLE : S_HOLD;
        end else if (stop) begin
          abort_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (stop) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (cnt_q <= TEMPO_ONE) begin
          cnt_n = '0;
          if (!last_note) begin
            idx_n   = note_idx + 1'b1;
            state_n = S_LOAD;
          end else if (loop_q) begin
            idx_n   = '0;
            state_n = S_LOAD;
          end else begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apu_pulse_sequencer.sv
// Directed bench for apu_pulse_sequencer: cycle-exact checks of handshakes,
// hold timing, looping, stop and reset behaviour.
module tb_apu_pulse_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [12:0] wr_data = '0;
  logic [3:0]  len = '0;
  logic [15:0] tempo = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] period_s;
  logic        period_s_vld;
  logic        period_s_rdy = 1'b1;
  logic [1:0]  duty_s;
  logic        duty_s_vld;
  logic        duty_s_rdy = 1'b1;
  logic        busy;
  logic [2:0]  note_idx;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apu_pulse_sequencer #(.DEPTH(8), .ADDR_W(3), .TEMPO_W(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .tempo(tempo), .loop(loop), .start(start), .stop(stop),
    .period_s(period_s), .period_s_vld(period_s_vld), .period_s_rdy(period_s_rdy),
    .duty_s(duty_s), .duty_s_vld(duty_s_vld), .duty_s_rdy(duty_s_rdy),
    .busy(busy), .note_idx(note_idx), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [1:0] d, input logic [10:0] p);
    wr_en = 1'b1; wr_addr = a; wr_data = {d, p};
    tick();
    wr_en = 1'b0;
  endtask

  // Returns just after the edge that samples start (cycle k=0).
  task automatic do_start(input logic [3:0] l, input logic [15:0] t, input logic lp);
    len = l; tempo = t; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || period_s_vld !== 1'b0 || duty_s_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b pv=%b dv=%b expected all 0", busy, done, period_s_vld, duty_s_vld);
    end
    checks++;
    if (note_idx !== 3'd0 || period_s !== 11'd0 || duty_s !== 2'd0) begin
      failures++;
      $display("FAIL reset_data idx=%0d period=%h duty=%0d expected 0", note_idx, period_s, duty_s);
    end
  endtask

  task automatic test_basic();
    logic ev;
    write_entry(3'd0, 2'd2, 11'h1FD);
    write_entry(3'd1, 2'd1, 11'h0EF);
    period_s_rdy = 1'b1; duty_s_rdy = 1'b1;
    do_start(4'd2, 16'd4, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL basic_busy0 got=%b expected=1", busy);
    end
    for (int k = 1; k <= 14; k++) begin
      tick();
      ev = (k == 1 || k == 7);
      checks++;
      if (period_s_vld !== ev || duty_s_vld !== ev) begin
        failures++; $display("FAIL basic_vld k=%0d pv=%b dv=%b expected=%b", k, period_s_vld, duty_s_vld, ev);
      end
      checks++;
      if (done !== (k == 12)) begin
        failures++; $display("FAIL basic_done k=%0d got=%b expected=%b", k, done, (k == 12));
      end
      checks++;
      if (busy !== (k < 12)) begin
        failures++; $display("FAIL basic_busy k=%0d got=%b expected=%b", k, busy, (k < 12));
      end
      if (k == 1) begin
        checks++;
        if (period_s !== 11'h1FD || duty_s !== 2'd2) begin
          failures++; $display("FAIL basic_data0 period=%h duty=%0d expected 1fd/2", period_s, duty_s);
        end
      end
      if (k == 7) begin
        checks++;
        if (period_s !== 11'h0EF || duty_s !== 2'd1 || note_idx !== 3'd1) begin
          failures++; $display("FAIL basic_data1 period=%h duty=%0d idx=%0d expected 0ef/1/1", period_s, duty_s, note_idx);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic epv, edv;
    period_s_rdy = 1'b0; duty_s_rdy = 1'b1;
    do_start(4'd2, 16'd4, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      epv = (k >= 1 && k <= 6) || (k == 12);
      edv = (k == 1) || (k == 12);
      checks++;
      if (period_s_vld !== epv || duty_s_vld !== edv) begin
        failures++; $display("FAIL bp_vld k=%0d pv=%b dv=%b expected pv=%b dv=%b", k, period_s_vld, duty_s_vld, epv, edv);
      end
      if (k <= 6) begin
        checks++;
        if (period_s !== 11'h1FD) begin
          failures++; $display("FAIL bp_stable k=%0d period=%h expected=1fd", k, period_s);
        end
      end
      if (k == 12) begin
        checks++;
        if (period_s !== 11'h0EF) begin
          failures++; $display("FAIL bp_note1 period=%h expected=0ef", period_s);
        end
      end
      checks++;
      if (done !== (k == 17) || busy !== (k < 17)) begin
        failures++; $display("FAIL bp_done k=%0d done=%b busy=%b expected done=%b busy=%b", k, done, busy, (k == 17), (k < 17));
      end
      period_s_rdy = (k >= 6);
    end
  endtask

  task automatic test_loop();
    logic       ev;
    logic [2:0] eidx;
    write_entry(3'd2, 2'd3, 11'h123);
    period_s_rdy = 1'b1; duty_s_rdy = 1'b1;
    do_start(4'd3, 16'd2, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      tick();
      ev = (k % 4 == 1);
      eidx = 3'(((k - 1) / 4) % 3);
      checks++;
      if (period_s_vld !== ev || done !== 1'b0) begin
        failures++; $display("FAIL loop_vld k=%0d pv=%b done=%b expected pv=%b done=0", k, period_s_vld, done, ev);
      end
      if (ev) begin
        checks++;
        if (note_idx !== eidx) begin
          failures++; $display("FAIL loop_idx k=%0d got=%0d expected=%0d", k, note_idx, eidx);
        end
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b0 || period_s_vld !== 1'b0 || duty_s_vld !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL loop_stop k=%0d busy=%b pv=%b dv=%b done=%b expected 0", k, busy, period_s_vld, duty_s_vld, done);
      end
      tick();
    end
  endtask

  task automatic test_stop_in_send();
    logic epv;
    period_s_rdy = 1'b0; duty_s_rdy = 1'b1;
    do_start(4'd2, 16'd4, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      epv = (k <= 4);
      checks++;
      if (period_s_vld !== epv || duty_s_vld !== (k == 1)) begin
        failures++; $display("FAIL stop_send_vld k=%0d pv=%b dv=%b expected pv=%b dv=%b", k, period_s_vld, duty_s_vld, epv, (k == 1));
      end
      checks++;
      if (busy !== (k <= 4) || done !== 1'b0) begin
        failures++; $display("FAIL stop_send_busy k=%0d busy=%b done=%b expected busy=%b done=0", k, busy, done, (k <= 4));
      end
      stop = (k == 2);
      period_s_rdy = (k >= 4);
    end
  endtask

  task automatic test_len_zero_tempo_zero();
    period_s_rdy = 1'b1; duty_s_rdy = 1'b1;
    do_start(4'd0, 16'd4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || period_s_vld !== 1'b0) begin
        failures++; $display("FAIL len0 k=%0d busy=%b done=%b pv=%b expected 0", k, busy, done, period_s_vld);
      end
      tick();
    end
    len = 4'd2; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || period_s_vld !== 1'b0) begin
      failures++; $display("FAIL start_stop busy=%b pv=%b expected 0", busy, period_s_vld);
    end
    do_start(4'd1, 16'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (period_s_vld !== (k == 1) || busy !== (k < 3) || done !== (k == 3)) begin
        failures++; $display("FAIL tempo0 k=%0d pv=%b busy=%b done=%b expected pv=%b busy=%b done=%b",
                             k, period_s_vld, busy, done, (k == 1), (k < 3), (k == 3));
      end
    end
  endtask

  task automatic test_reset_mid_send();
    period_s_rdy = 1'b0; duty_s_rdy = 1'b0;
    do_start(4'd2, 16'd4, 1'b0);
    tick();
    checks++;
    if (period_s_vld !== 1'b1 || duty_s_vld !== 1'b1) begin
      failures++; $display("FAIL rst_pre pv=%b dv=%b expected 1", period_s_vld, duty_s_vld);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (period_s_vld !== 1'b0 || duty_s_vld !== 1'b0 || busy !== 1'b0 || note_idx !== 3'd0) begin
      failures++; $display("FAIL rst_mid pv=%b dv=%b busy=%b idx=%0d expected 0", period_s_vld, duty_s_vld, busy, note_idx);
    end
    period_s_rdy = 1'b1; duty_s_rdy = 1'b1;
    do_start(4'd1, 16'd1, 1'b0);
    tick();
    checks++;
    if (period_s_vld !== 1'b1 || period_s !== 11'd0 || duty_s !== 2'd0) begin
      failures++; $display("FAIL rst_table pv=%b period=%h duty=%0d expected 1/000/0", period_s_vld, period_s, duty_s);
    end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_loop();
    test_stop_in_send();
    test_len_zero_tempo_zero();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
